// File: rtl/cnn_mac_pipe_sat.sv
// Pipelined signed multiply-accumulate with valid/ready streaming,
// group accumulation delimited by first/last flags, and a shifted,
// saturated group result.
module cnn_mac_pipe_sat #(
   parameter int unsigned A_W       = 10,
   parameter int unsigned B_W       = 14,
   parameter int unsigned ACC_W     = 32,
   parameter int unsigned OUT_W     = 24,
   parameter int unsigned SHIFT     = 0,
   parameter int unsigned NUM_STAGE = 3
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [A_W-1:0]   din0,
   input  logic [B_W-1:0]   din1,
   input  logic             acc_first,
   input  logic             acc_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] dout,
   output logic             dout_sat
);

   localparam int unsigned P_W  = A_W + B_W;
   localparam int unsigned LAST = NUM_STAGE - 1;

   // Saturation bounds expressed at accumulator width
   localparam logic signed [ACC_W-1:0] L_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] L_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [P_W-1:0]   r_prod [NUM_STAGE];
   logic [NUM_STAGE-1:0]    r_vld;
   logic [NUM_STAGE-1:0]    r_first;
   logic [NUM_STAGE-1:0]    r_last;
   logic signed [ACC_W-1:0] r_acc;

   logic                    w_en;
   logic                    w_step;
   logic signed [P_W-1:0]   w_prod;
   logic signed [ACC_W-1:0] w_base;
   logic signed [ACC_W-1:0] w_sum;
   logic signed [ACC_W-1:0] w_shr;
   logic [OUT_W-1:0]        w_dout_nxt;
   logic                    w_sat_nxt;

   // Whole pipeline stalls only when a held result is not being taken
   assign w_en     = !(out_valid && !out_ready);
   assign in_ready = w_en;

   assign w_prod = P_W'($signed(din0)) * P_W'($signed(din1));
   assign w_step = r_vld[LAST] && w_en;

   // Product pipeline: stage 0 captures, later stages shift forward
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_vld   <= '0;
         r_first <= '0;
         r_last  <= '0;
         for (int unsigned i = 0; i < NUM_STAGE; i++) begin
            r_prod[i] <= '0;
         end
      end else if (w_en) begin
         r_prod[0]  <= w_prod;
         r_vld[0]   <= in_valid;
         r_first[0] <= acc_first;
         r_last[0]  <= acc_last;
         for (int unsigned i = 1; i < NUM_STAGE; i++) begin
            r_prod[i]  <= r_prod[i-1];
            r_vld[i]   <= r_vld[i-1];
            r_first[i] <= r_first[i-1];
            r_last[i]  <= r_last[i-1];
         end
      end
   end

   // Wrapping group sum, then shift and clamp to the output range
   always_comb begin
      w_base     = r_first[LAST] ? '0 : r_acc;
      w_sum      = w_base + ACC_W'(r_prod[LAST]);
      w_shr      = w_sum >>> SHIFT;
      w_dout_nxt = w_shr[OUT_W-1:0];
      w_sat_nxt  = 1'b0;
      if (w_shr > L_MAX) begin
         w_dout_nxt = L_MAX[OUT_W-1:0];
         w_sat_nxt  = 1'b1;
      end else if (w_shr < L_MIN) begin
         w_dout_nxt = L_MIN[OUT_W-1:0];
         w_sat_nxt  = 1'b1;
      end
   end

   // Accumulator clears after a last beat so the next group starts at 0
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_acc <= '0;
      end else if (w_step) begin
         r_acc <= r_last[LAST] ? '0 : w_sum;
      end
   end

   // Result register: load on last beat, otherwise drain on handshake
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         out_valid <= 1'b0;
         dout      <= '0;
         dout_sat  <= 1'b0;
      end else if (w_step && r_last[LAST]) begin
         out_valid <= 1'b1;
         dout      <= w_dout_nxt;
         dout_sat  <= w_sat_nxt;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cnn_mac_pipe_sat.sv
// Directed bench for cnn_mac_pipe_sat; a second instance uses SHIFT=2.
module tb_cnn_mac_pipe_sat;

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready, in_ready2;
   logic [9:0]  din0 = '0;
   logic [13:0] din1 = '0;
   logic        acc_first = 1'b0;
   logic        acc_last = 1'b0;
   logic        out_valid, out_valid2;
   logic        out_ready = 1'b1;
   logic [23:0] dout, dout2;
   logic        dout_sat, dout_sat2;

   int n_checks = 0;
   int n_errors = 0;
   int n;

   always #5 ap_clk = ~ap_clk;

   cnn_mac_pipe_sat u_dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
      .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
      .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .dout_sat(dout_sat)
   );

   cnn_mac_pipe_sat #(.SHIFT(2)) u_shift (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready2),
      .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
      .out_valid(out_valid2), .out_ready(out_ready), .dout(dout2), .dout_sat(dout_sat2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input int exp_val, input bit exp_sat);
      logic [23:0] e;
      e = 24'(exp_val);
      check({tag, "_dout"}, {8'h0, dout}, {8'h0, e});
      check({tag, "_sat"}, 32'(dout_sat), 32'(exp_sat));
   endtask

   task automatic check_out2(input string tag, input int exp_val, input bit exp_sat);
      logic [23:0] e;
      e = 24'(exp_val);
      check({tag, "_dout_sh2"}, {8'h0, dout2}, {8'h0, e});
      check({tag, "_sat_sh2"}, 32'(dout_sat2), 32'(exp_sat));
   endtask

   task automatic step();
      @(negedge ap_clk);
   endtask

   // Present one beat for one edge; the beat must be accepted
   task automatic beat(input int a, input int b, input bit f, input bit l, input string tag);
      din0      = 10'(a);
      din1      = 14'(b);
      acc_first = f;
      acc_last  = l;
      in_valid  = 1'b1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      step();
      in_valid  = 1'b0;
      acc_first = 1'b0;
      acc_last  = 1'b0;
   endtask

   // Bounded wait for a result; n counts edges waited
   task automatic wait_out(input string tag, output int cnt);
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 20) begin
         step();
         cnt++;
      end
      check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
   endtask

   initial begin
      // Reset state
      step();
      step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check_out("rst", 0, 1'b0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      ap_rst = 1'b0;
      step();

      // Single beat, latency NUM_STAGE edges after accept
      beat(-3, 100, 1'b1, 1'b1, "t1");
      wait_out("t1", n);
      check("t1_latency", 32'(n), 32'd3);
      check_out("t1", -300, 1'b0);
      check_out2("t1", -75, 1'b0);
      step();
      check("t1_drain", 32'(out_valid), 32'd0);

      // Operand extremes
      beat(-512, -8192, 1'b1, 1'b1, "t2a");
      wait_out("t2a", n);
      check_out("t2a", 4194304, 1'b0);
      step();
      beat(511, -8192, 1'b1, 1'b1, "t2b");
      wait_out("t2b", n);
      check_out("t2b", -4186112, 1'b0);
      step();

      // Three-beat group saturating; shifted instance stays in range
      beat(511, 8191, 1'b1, 1'b0, "t3a");
      beat(511, 8191, 1'b0, 1'b0, "t3b");
      beat(511, 8191, 1'b0, 1'b1, "t3c");
      wait_out("t3", n);
      check_out("t3", 8388607, 1'b1);
      check_out2("t3", 3139200, 1'b0);
      step();

      // Backpressure: four results, downstream stalled 6 cycles
      out_ready = 1'b0;
      beat(1, 1, 1'b1, 1'b1, "t4a");
      beat(2, 2, 1'b1, 1'b1, "t4b");
      beat(3, 3, 1'b1, 1'b1, "t4c");
      beat(4, 4, 1'b1, 1'b1, "t4d");
      check("t4_out_valid", 32'(out_valid), 32'd1);
      check("t4_in_ready_low", 32'(in_ready), 32'd0);
      check_out("t4_first", 1, 1'b0);
      step();
      step();
      check("t4_hold_in_ready", 32'(in_ready), 32'd0);
      check_out("t4_hold", 1, 1'b0);
      out_ready = 1'b1;
      step();
      check("t4_r2_valid", 32'(out_valid), 32'd1);
      check_out("t4_r2", 4, 1'b0);
      step();
      check("t4_r3_valid", 32'(out_valid), 32'd1);
      check_out("t4_r3", 9, 1'b0);
      step();
      check("t4_r4_valid", 32'(out_valid), 32'd1);
      check_out("t4_r4", 16, 1'b0);
      step();
      check("t4_drain", 32'(out_valid), 32'd0);

      // Reset in the middle of an open group
      beat(5, 5, 1'b1, 1'b0, "t5a");
      beat(5, 5, 1'b0, 1'b0, "t5b");
      ap_rst = 1'b1;
      step();
      check("t5_rst_valid", 32'(out_valid), 32'd0);
      check_out("t5_rst", 0, 1'b0);
      ap_rst = 1'b0;
      repeat (5) step();
      check("t5_quiet", 32'(out_valid), 32'd0);
      beat(2, 3, 1'b1, 1'b0, "t5c");
      beat(2, 3, 1'b0, 1'b1, "t5d");
      wait_out("t5", n);
      check_out("t5", 12, 1'b0);
      step();

      // Back-to-back groups at full rate
      beat(1, 7, 1'b1, 1'b0, "t6a");
      beat(1, 7, 1'b0, 1'b1, "t6b");
      beat(-1, 3, 1'b1, 1'b1, "t6c");
      beat(2, 2, 1'b1, 1'b0, "t6d");
      beat(2, 2, 1'b0, 1'b0, "t6e");
      check("t6_r1_valid", 32'(out_valid), 32'd1);
      check_out("t6_r1", 14, 1'b0);
      beat(2, 2, 1'b0, 1'b1, "t6f");
      check("t6_r2_valid", 32'(out_valid), 32'd1);
      check_out("t6_r2", -3, 1'b0);
      step();
      wait_out("t6_r3", n);
      check("t6_r3_latency", 32'(n), 32'd2);
      check_out("t6_r3", 12, 1'b0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
